// File: rtl/display_pkg.sv
// Shared pixel type and default panel timing for the scan-out path.
package display_pkg;
   typedef logic [23:0] pixel_t;

   localparam int H_ACTIVE_DEF   = 480;
   localparam int H_FP_DEF       = 2;
   localparam int H_SYNC_DEF     = 41;
   localparam int H_BP_DEF       = 2;
   localparam int V_ACTIVE_DEF   = 272;
   localparam int V_FP_DEF       = 2;
   localparam int V_SYNC_DEF     = 10;
   localparam int V_BP_DEF       = 2;
   localparam int FIFO_DEPTH_DEF = 16;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with combinational head read; zero-latency pop data.
// push is ignored when full, pop when empty; flush empties it and overrides both.
module pixel_fifo
   import display_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  logic   flush,
   input  pixel_t push_dat,
   output pixel_t pop_dat,
   output logic   full,
   output logic   empty
);
   localparam int AW = $clog2(DEPTH);

   pixel_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign pop_dat = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

// File: rtl/display_scanout.sv
// Raster timing generator draining a pixel FIFO onto registered RGB/DE/sync outputs.
// Outputs lag counter state by one clock; pixel_ready_o drops when full, in flush, or in reset.
module display_scanout
   import display_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   pixel_valid_i,
   output logic   pixel_ready_o,
   input  pixel_t pixel_data_i,
   output logic   frame_idx_o,
   output pixel_t rgb_o,
   output logic   de_o,
   output logic   hsync_o,
   output logic   vsync_o,
   output logic   underrun_o
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_wrap;
   logic          v_wrap;
   logic          active;
   logic          hsync_d;
   logic          vsync_d;
   logic          flush;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   pixel_t        fifo_dat;

   assign h_wrap  = (int'(h_cnt) == H_TOTAL - 1);
   assign v_wrap  = (int'(v_cnt) == V_TOTAL - 1);
   assign active  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
   assign hsync_d = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
   assign vsync_d = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
   // First clock of vertical blanking: drop leftovers so the next frame starts aligned.
   assign flush   = (h_cnt == '0) && (int'(v_cnt) == V_ACTIVE);

   assign pixel_ready_o = !fifo_full && !flush && !rst_i;
   assign push          = pixel_valid_i && pixel_ready_o;
   assign pop           = active && !fifo_empty;

   pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .push_dat (pixel_data_i),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         de_o        <= 1'b0;
         hsync_o     <= 1'b0;
         vsync_o     <= 1'b0;
         rgb_o       <= '0;
         underrun_o  <= 1'b0;
         frame_idx_o <= 1'b0;
      end else begin
         de_o        <= active;
         hsync_o     <= hsync_d;
         vsync_o     <= vsync_d;
         rgb_o       <= pop ? fifo_dat : '0;
         underrun_o  <= active && fifo_empty;
         frame_idx_o <= frame_idx_o ^ flush;
      end
   end
endmodule
